// File: rtl/comp_block_engine.sv
// comp_block_engine: moves one BLOCK_LEN-byte block from the receive FIFO to the send FIFO, then pulses done.
// Build option: define COMP_XOR_MASK_EN to XOR each byte with (KEY + byte index) mod 256; otherwise bytes loop back unchanged.
module comp_block_engine #(
    parameter int         BLOCK_LEN = 32,
    parameter logic [7:0] KEY       = 8'hA5
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic       In_comp_enable,
    output logic       Out_comp_done,
    output logic       Out_busy,
    input  logic       In_rcv_empty,
    input  logic [7:0] In_rcv_dout,
    output logic       Out_rcv_rd_en,
    input  logic       In_snd_full,
    output logic       Out_snd_wr_en,
    output logic [7:0] Out_snd_din,
    output logic [5:0] Out_byte_cnt
);

    typedef enum logic [2:0] {IDLE, RD, LAT, WR, DONE} state_t;

    localparam logic [5:0] LAST_IDX = 6'(BLOCK_LEN - 1);

    state_t     state;
    state_t     state_nxt;
    logic       vld_p1;
    logic [7:0] data_r;
    logic [7:0] wr_data;
    logic [7:0] din_val;

    logic       rd_en_nxt;
    logic       wr_en_nxt;
    logic       done_nxt;
    logic       busy_nxt;
    logic [5:0] cnt_nxt;
    logic [7:0] din_nxt;

    // FIFO data is only on In_rcv_dout in the first WR cycle; after that (full stall) use the captured copy
    assign wr_data = vld_p1 ? In_rcv_dout : data_r;

`ifdef COMP_XOR_MASK_EN
    logic [7:0] mask;
    assign mask    = KEY + {2'b00, Out_byte_cnt};
    assign din_val = wr_data ^ mask;
`else
    logic unused_key;
    assign unused_key = ^KEY;
    assign din_val    = wr_data;
`endif

    always_comb begin
        state_nxt = state;
        rd_en_nxt = 1'b0;
        wr_en_nxt = 1'b0;
        done_nxt  = 1'b0;
        cnt_nxt   = Out_byte_cnt;
        din_nxt   = Out_snd_din;
        case (state)
            IDLE: begin
                if (In_comp_enable) begin
                    cnt_nxt   = 6'd0;
                    state_nxt = RD;
                end
            end
            RD: begin
                if (!In_rcv_empty) begin
                    rd_en_nxt = 1'b1;
                    state_nxt = LAT;
                end
            end
            LAT: begin
                state_nxt = WR;
            end
            WR: begin
                if (!In_snd_full) begin
                    wr_en_nxt = 1'b1;
                    din_nxt   = din_val;
                    cnt_nxt   = Out_byte_cnt + 6'd1;
                    state_nxt = (Out_byte_cnt == LAST_IDX) ? DONE : RD;
                end
            end
            DONE: begin
                done_nxt  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        // busy stays up through the done pulse so both fall on the same edge
        busy_nxt = (state_nxt != IDLE) || (state == DONE);
    end

    // stage p0 -> p1: state and registered strobes
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state         <= IDLE;
            vld_p1        <= 1'b0;
            Out_rcv_rd_en <= 1'b0;
            Out_snd_wr_en <= 1'b0;
            Out_comp_done <= 1'b0;
            Out_busy      <= 1'b0;
            Out_byte_cnt  <= 6'd0;
            Out_snd_din   <= 8'h00;
        end else begin
            state         <= state_nxt;
            vld_p1        <= Out_rcv_rd_en;
            Out_rcv_rd_en <= rd_en_nxt;
            Out_snd_wr_en <= wr_en_nxt;
            Out_comp_done <= done_nxt;
            Out_busy      <= busy_nxt;
            Out_byte_cnt  <= cnt_nxt;
            Out_snd_din   <= din_nxt;
        end
    end

    // stage p1: capture FIFO read data
    always_ff @(posedge Clk) begin
        if (vld_p1) begin
            data_r <= In_rcv_dout;
        end
    end

endmodule

// File: tb/tb_comp_block_engine.sv
// Self-checking bench for comp_block_engine: FIFO models around the DUT and a byte-level reference model.
`timescale 1ns/1ps
module tb_comp_block_engine;

    localparam int         BL  = 32;
    localparam logic [7:0] KEY = 8'hF0;

    logic       Clk = 1'b0;
    logic       Rst_n = 1'b0;
    logic       In_comp_enable = 1'b0;
    logic       In_rcv_empty;
    logic [7:0] In_rcv_dout;
    logic       In_snd_full = 1'b0;
    logic       Out_comp_done;
    logic       Out_busy;
    logic       Out_rcv_rd_en;
    logic       Out_snd_wr_en;
    logic [7:0] Out_snd_din;
    logic [5:0] Out_byte_cnt;

    always #5 Clk = ~Clk;

    comp_block_engine #(.BLOCK_LEN(BL), .KEY(KEY)) dut (
        .Clk(Clk),
        .Rst_n(Rst_n),
        .In_comp_enable(In_comp_enable),
        .Out_comp_done(Out_comp_done),
        .Out_busy(Out_busy),
        .In_rcv_empty(In_rcv_empty),
        .In_rcv_dout(In_rcv_dout),
        .Out_rcv_rd_en(Out_rcv_rd_en),
        .In_snd_full(In_snd_full),
        .Out_snd_wr_en(Out_snd_wr_en),
        .Out_snd_din(Out_snd_din),
        .Out_byte_cnt(Out_byte_cnt)
    );

    int n_chk = 0;
    int n_pass = 0;

    // receive FIFO model (standard read: data appears after the rd_en edge)
    logic [7:0] rmem [0:255];
    int rwp = 0;
    int rrp = 0;
    bit flush = 1'b0;
    assign In_rcv_empty = (rwp == rrp);

    int cyc = 0;
    int rd_viol = 0;
    int wr_viol = 0;
    logic [7:0] sq[$];
    int wcyc[$];
    int done_q[$];
    logic [7:0] exp_q[$];

    always @(posedge Clk) begin
        cyc <= cyc + 1;
        if (flush) rrp <= rwp;
        else if (Out_rcv_rd_en) begin
            if (rwp == rrp) rd_viol <= rd_viol + 1;
            else begin
                In_rcv_dout <= rmem[rrp % 256];
                rrp <= rrp + 1;
            end
        end
        if (Out_snd_wr_en) begin
            if (In_snd_full) wr_viol <= wr_viol + 1;
            sq.push_back(Out_snd_din);
            wcyc.push_back(cyc);
        end
        if (Out_comp_done) done_q.push_back(cyc);
    end

    function automatic logic [7:0] model(input logic [7:0] d, input int idx);
`ifdef COMP_XOR_MASK_EN
        int m;
        m = (int'(KEY) + idx) % 256;
        return d ^ m[7:0];
`else
        return d;
`endif
    endfunction

    task automatic load(input logic [7:0] d, input int idx);
        rmem[rwp % 256] = d;
        rwp = rwp + 1;
        exp_q.push_back(model(d, idx));
    endtask

    task automatic clear_logs();
        sq.delete();
        wcyc.delete();
        done_q.delete();
        exp_q.delete();
    endtask

    task automatic start_block(output int c0);
        @(negedge Clk);
        In_comp_enable = 1'b1;
        c0 = cyc;
        @(negedge Clk);
        In_comp_enable = 1'b0;
    endtask

    task automatic wait_dones(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && done_q.size() < n; i++) @(negedge Clk);
        ok = (done_q.size() >= n);
    endtask

    task automatic wait_writes(input int n, input int budget, output bit ok);
        for (int i = 0; i < budget && sq.size() < n; i++) @(negedge Clk);
        ok = (sq.size() >= n);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge Clk);
        n_chk++; if (Out_comp_done !== 1'b0) $display("FAIL reset_done: got %b expected 0", Out_comp_done); else n_pass++;
        n_chk++; if (Out_busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", Out_busy); else n_pass++;
        n_chk++; if (Out_rcv_rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b expected 0", Out_rcv_rd_en); else n_pass++;
        n_chk++; if (Out_snd_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b expected 0", Out_snd_wr_en); else n_pass++;
        n_chk++; if (Out_snd_din !== 8'h00) $display("FAIL reset_din: got %h expected 00", Out_snd_din); else n_pass++;
        n_chk++; if (Out_byte_cnt !== 6'd0) $display("FAIL reset_cnt: got %0d expected 0", Out_byte_cnt); else n_pass++;
        Rst_n = 1'b1;
        repeat (2) @(negedge Clk);
    endtask

    task automatic test_basic();
        int c0;
        bit ok;
        clear_logs();
        for (int k = 0; k < BL; k++) load(8'(k), k);
        start_block(c0);
        n_chk++; if (Out_busy !== 1'b1) $display("FAIL basic_busy_start: got %b expected 1", Out_busy); else n_pass++;
        n_chk++; if (Out_byte_cnt !== 6'd0) $display("FAIL basic_cnt_start: got %0d expected 0", Out_byte_cnt); else n_pass++;
        wait_dones(1, 400, ok);
        n_chk++; if (!ok) $display("FAIL basic_timeout: got %0d dones expected 1", done_q.size()); else n_pass++;
        repeat (10) @(negedge Clk);
        n_chk++; if (sq.size() != BL) $display("FAIL basic_count: got %0d writes expected %0d", sq.size(), BL); else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            n_chk++;
            if (k >= sq.size() || sq[k] !== exp_q[k])
                $display("FAIL basic_byte%0d: got %h expected %h", k, (k < sq.size()) ? sq[k] : 8'hxx, exp_q[k]);
            else n_pass++;
        end
        n_chk++; if (done_q.size() != 1) $display("FAIL basic_done_cnt: got %0d expected 1", done_q.size()); else n_pass++;
        n_chk++; if (done_q.size() < 1 || done_q[0] != c0 + 2 + 3 * BL)
            $display("FAIL basic_done_cyc: got %0d expected %0d", (done_q.size() > 0) ? done_q[0] - c0 : -1, 2 + 3 * BL); else n_pass++;
        n_chk++; if (wcyc.size() < 1 || wcyc[0] != c0 + 4)
            $display("FAIL basic_first_wr_cyc: got %0d expected 4", (wcyc.size() > 0) ? wcyc[0] - c0 : -1); else n_pass++;
        n_chk++; if (wcyc.size() < BL || wcyc[BL-1] != c0 + 1 + 3 * BL)
            $display("FAIL basic_last_wr_cyc: got %0d expected %0d", (wcyc.size() >= BL) ? wcyc[BL-1] - c0 : -1, 1 + 3 * BL); else n_pass++;
        n_chk++; if (Out_busy !== 1'b0) $display("FAIL basic_busy_end: got %b expected 0", Out_busy); else n_pass++;
        n_chk++; if (Out_byte_cnt !== 6'(BL)) $display("FAIL basic_cnt_end: got %0d expected %0d", Out_byte_cnt, BL); else n_pass++;
    endtask

    task automatic test_mask_wrap();
        bit ok;
        logic [7:0] d;
        clear_logs();
        for (int k = 0; k < BL; k++) begin
            d = 8'($urandom_range(0, 255));
            if (k == 31) d = 8'hFF;
            if (k == 16) d = 8'h00;
            load(d, k);
        end
        // enable held well into the block: the deassertion must not matter
        @(negedge Clk);
        In_comp_enable = 1'b1;
        repeat (20) @(negedge Clk);
        In_comp_enable = 1'b0;
        wait_dones(1, 400, ok);
        n_chk++; if (!ok) $display("FAIL wrap_timeout: got %0d dones expected 1", done_q.size()); else n_pass++;
        repeat (10) @(negedge Clk);
        n_chk++; if (sq.size() != BL) $display("FAIL wrap_count: got %0d writes expected %0d", sq.size(), BL); else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            n_chk++;
            if (k >= sq.size() || sq[k] !== exp_q[k])
                $display("FAIL wrap_byte%0d: got %h expected %h", k, (k < sq.size()) ? sq[k] : 8'hxx, exp_q[k]);
            else n_pass++;
        end
`ifdef COMP_XOR_MASK_EN
        n_chk++; if (sq.size() < BL || sq[31] !== 8'hF0) $display("FAIL wrap_idx31: got %h expected f0", (sq.size() >= BL) ? sq[31] : 8'hxx); else n_pass++;
`else
        n_chk++; if (sq.size() < BL || sq[31] !== 8'hFF) $display("FAIL wrap_idx31: got %h expected ff", (sq.size() >= BL) ? sq[31] : 8'hxx); else n_pass++;
`endif
        n_chk++; if (sq.size() < BL || sq[16] !== 8'h00) $display("FAIL wrap_idx16: got %h expected 00", (sq.size() >= BL) ? sq[16] : 8'hxx); else n_pass++;
        n_chk++; if (done_q.size() != 1) $display("FAIL wrap_done_cnt: got %0d expected 1", done_q.size()); else n_pass++;
    endtask

    task automatic test_empty_stall();
        int c0;
        bit ok;
        int bad_rd;
        clear_logs();
        bad_rd = 0;
        for (int k = 0; k < 5; k++) load(8'($urandom_range(0, 255)), k);
        start_block(c0);
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (In_rcv_empty && Out_rcv_rd_en) bad_rd++;
        end
        n_chk++; if (sq.size() != 5) $display("FAIL empty_partial: got %0d writes expected 5", sq.size()); else n_pass++;
        n_chk++; if (Out_busy !== 1'b1) $display("FAIL empty_busy: got %b expected 1", Out_busy); else n_pass++;
        n_chk++; if (Out_rcv_rd_en !== 1'b0) $display("FAIL empty_rd_en: got %b expected 0", Out_rcv_rd_en); else n_pass++;
        for (int k = 5; k < BL; k++) load(8'($urandom_range(0, 255)), k);
        wait_dones(1, 400, ok);
        n_chk++; if (!ok) $display("FAIL empty_timeout: got %0d dones expected 1", done_q.size()); else n_pass++;
        repeat (10) @(negedge Clk);
        n_chk++; if (sq.size() != BL) $display("FAIL empty_count: got %0d writes expected %0d", sq.size(), BL); else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            n_chk++;
            if (k >= sq.size() || sq[k] !== exp_q[k])
                $display("FAIL empty_byte%0d: got %h expected %h", k, (k < sq.size()) ? sq[k] : 8'hxx, exp_q[k]);
            else n_pass++;
        end
        n_chk++; if (rd_viol != 0 || bad_rd != 0) $display("FAIL empty_read_viol: got %0d expected 0", rd_viol + bad_rd); else n_pass++;
        n_chk++; if (done_q.size() != 1) $display("FAIL empty_done_cnt: got %0d expected 1", done_q.size()); else n_pass++;
    endtask

    task automatic test_full_stall();
        int c0;
        bit ok;
        int bad;
        logic [7:0] d0;
        clear_logs();
        bad = 0;
        for (int k = 0; k < BL; k++) load(8'($urandom_range(0, 255)), k);
        start_block(c0);
        wait_writes(10, 200, ok);
        n_chk++; if (!ok) $display("FAIL full_reach10: got %0d writes expected 10", sq.size()); else n_pass++;
        In_snd_full = 1'b1;
        d0 = Out_snd_din;
        for (int i = 0; i < 50; i++) begin
            @(negedge Clk);
            if (Out_snd_wr_en !== 1'b0 || Out_snd_din !== d0) bad++;
        end
        n_chk++; if (bad != 0) $display("FAIL full_stable: got %0d unstable cycles expected 0", bad); else n_pass++;
        n_chk++; if (sq.size() != 10) $display("FAIL full_held: got %0d writes expected 10", sq.size()); else n_pass++;
        In_snd_full = 1'b0;
        wait_dones(1, 400, ok);
        n_chk++; if (!ok) $display("FAIL full_timeout: got %0d dones expected 1", done_q.size()); else n_pass++;
        repeat (10) @(negedge Clk);
        n_chk++; if (sq.size() != BL) $display("FAIL full_count: got %0d writes expected %0d", sq.size(), BL); else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            n_chk++;
            if (k >= sq.size() || sq[k] !== exp_q[k])
                $display("FAIL full_byte%0d: got %h expected %h", k, (k < sq.size()) ? sq[k] : 8'hxx, exp_q[k]);
            else n_pass++;
        end
        n_chk++; if (wr_viol != 0) $display("FAIL full_write_viol: got %0d expected 0", wr_viol); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int c0;
        bit ok;
        clear_logs();
        for (int k = 0; k < BL; k++) load(8'($urandom_range(1, 255)), k);
        start_block(c0);
        wait_writes(8, 200, ok);
        n_chk++; if (!ok) $display("FAIL rstmid_reach8: got %0d writes expected 8", sq.size()); else n_pass++;
        @(posedge Clk);
        #2 Rst_n = 1'b0;
        #1;
        n_chk++; if (Out_busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", Out_busy); else n_pass++;
        n_chk++; if (Out_byte_cnt !== 6'd0) $display("FAIL rstmid_cnt: got %0d expected 0", Out_byte_cnt); else n_pass++;
        n_chk++; if (Out_snd_din !== 8'h00) $display("FAIL rstmid_din: got %h expected 00", Out_snd_din); else n_pass++;
        n_chk++; if (Out_rcv_rd_en !== 1'b0 || Out_snd_wr_en !== 1'b0 || Out_comp_done !== 1'b0)
            $display("FAIL rstmid_strobes: got %b%b%b expected 000", Out_rcv_rd_en, Out_snd_wr_en, Out_comp_done); else n_pass++;
        @(negedge Clk);
        flush = 1'b1;
        @(negedge Clk);
        flush = 1'b0;
        Rst_n = 1'b1;
        @(negedge Clk);
        clear_logs();
        for (int k = 0; k < BL; k++) load(8'($urandom_range(0, 255)), k);
        start_block(c0);
        n_chk++; if (Out_byte_cnt !== 6'd0) $display("FAIL rstmid_restart_cnt: got %0d expected 0", Out_byte_cnt); else n_pass++;
        wait_dones(1, 400, ok);
        n_chk++; if (!ok) $display("FAIL rstmid_timeout: got %0d dones expected 1", done_q.size()); else n_pass++;
        repeat (10) @(negedge Clk);
        n_chk++; if (sq.size() != BL) $display("FAIL rstmid_count: got %0d writes expected %0d", sq.size(), BL); else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            n_chk++;
            if (k >= sq.size() || sq[k] !== exp_q[k])
                $display("FAIL rstmid_byte%0d: got %h expected %h", k, (k < sq.size()) ? sq[k] : 8'hxx, exp_q[k]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        bit ok;
        clear_logs();
        for (int k = 0; k < 2 * BL; k++) load(8'($urandom_range(0, 255)), k % BL);
        @(negedge Clk);
        In_comp_enable = 1'b1;
        c0 = cyc;
        wait_dones(1, 400, ok);
        In_comp_enable = 1'b0;
        n_chk++; if (!ok) $display("FAIL b2b_timeout1: got %0d dones expected 1", done_q.size()); else n_pass++;
        wait_dones(2, 400, ok);
        n_chk++; if (!ok) $display("FAIL b2b_timeout2: got %0d dones expected 2", done_q.size()); else n_pass++;
        repeat (10) @(negedge Clk);
        n_chk++; if (done_q.size() != 2) $display("FAIL b2b_done_cnt: got %0d expected 2", done_q.size()); else n_pass++;
        n_chk++; if (done_q.size() < 2 || done_q[1] != c0 + 2 * (2 + 3 * BL))
            $display("FAIL b2b_done2_cyc: got %0d expected %0d", (done_q.size() > 1) ? done_q[1] - c0 : -1, 2 * (2 + 3 * BL)); else n_pass++;
        n_chk++; if (sq.size() != 2 * BL) $display("FAIL b2b_count: got %0d writes expected %0d", sq.size(), 2 * BL); else n_pass++;
        for (int k = 0; k < exp_q.size(); k++) begin
            n_chk++;
            if (k >= sq.size() || sq[k] !== exp_q[k])
                $display("FAIL b2b_byte%0d: got %h expected %h", k, (k < sq.size()) ? sq[k] : 8'hxx, exp_q[k]);
            else n_pass++;
        end
        n_chk++; if (Out_busy !== 1'b0) $display("FAIL b2b_busy_end: got %b expected 0", Out_busy); else n_pass++;
        n_chk++; if (rd_viol != 0 || wr_viol != 0) $display("FAIL b2b_viol: got %0d expected 0", rd_viol + wr_viol); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_mask_wrap();
        test_empty_stall();
        test_full_stall();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
